// File: rtl/mide_pkg.sv
// Shared types and constants for the UART memory loader.
package mide_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_CHK
  } loader_state_t;

  localparam logic [7:0]  SYNC_BYTE_DEF  = 8'hA5;
  localparam int unsigned ADDR_LEN_BYTES = 4;
  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned ADDR_RAW_W     = ADDR_LEN_BYTES * 8;
  localparam int unsigned LEN_W          = LEN_BYTES * 8;

endpackage

// File: rtl/uart_mem_loader_if.sv
// Serial input and memory write port of the loader, plus its status flags.
interface uart_mem_loader_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              rx;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              load_done;
  logic              load_err;

  modport master (
    input  rx,
    output mem_we, mem_addr, mem_wdata, cpu_hold, busy, load_done, load_err
  );

  modport slave (
    output rx,
    input  mem_we, mem_addr, mem_wdata, cpu_hold, busy, load_done, load_err
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver working on an already-synchronised line.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_sync,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t        st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic             prev_q;
  logic             valid_d;
  logic [7:0]       byte_d;
  logic             ferr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      prev_q     <= 1'b1;
      byte_valid <= 1'b0;
      rx_byte    <= '0;
      frame_err  <= 1'b0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      prev_q     <= rx_sync;
      byte_valid <= valid_d;
      rx_byte    <= byte_d;
      frame_err  <= ferr_d;
    end
  end

  // Only a true high-to-low edge arms a start, so a low stop bit cannot re-trigger.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    byte_d  = rx_byte;
    ferr_d  = frame_err;
    case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !rx_sync) st_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          sh_d  = {rx_sync, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          valid_d = 1'b1;
          byte_d  = sh_q;
          ferr_d  = !rx_sync;
          st_d    = RX_IDLE;
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_mem_loader.sv
// Decodes SYNC/ADDR/LEN/data/CHK frames from a UART line into byte writes to data memory.
module uart_mem_loader
  import mide_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned ADDR_W       = 32,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  uart_mem_loader_if.master  bus
);

  logic [1:0] rx_sync_q;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_ferr;

  loader_state_t         state_q, state_d;
  logic [ADDR_RAW_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [7:0]            chk_q, chk_d;

  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              busy_q, busy_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;

  // Two-flop synchroniser; idles high like the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_sync_q <= 2'b11;
    else     rx_sync_q <= {rx_sync_q[0], bus.rx};
  end

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx_sync    (rx_sync_q[1]),
    .byte_valid (rx_valid),
    .rx_byte    (rx_byte),
    .frame_err  (rx_ferr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      chk_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      chk_q       <= chk_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  // Frame decoder: multi-byte fields shift in from the top so they land little-endian.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    chk_d       = chk_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    load_done_d = 1'b0;
    load_err_d  = load_err_q;
    if (rx_valid) begin
      if (state_q != S_IDLE && rx_ferr) begin
        state_d    = S_IDLE;
        cpu_hold_d = 1'b0;
        load_err_d = 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (rx_byte == SYNC_BYTE && !rx_ferr) begin
              state_d    = S_ADDR;
              cpu_hold_d = 1'b1;
              load_err_d = 1'b0;
              chk_d      = '0;
              cnt_d      = '0;
            end
          end
          S_ADDR: begin
            addr_d = {rx_byte, addr_q[ADDR_RAW_W-1:8]};
            chk_d  = chk_q ^ rx_byte;
            if (cnt_q == LEN_W'(ADDR_LEN_BYTES - 1)) begin
              cnt_d   = '0;
              state_d = S_LEN;
            end else begin
              cnt_d = cnt_q + LEN_W'(1);
            end
          end
          S_LEN: begin
            len_d = {rx_byte, len_q[LEN_W-1:8]};
            chk_d = chk_q ^ rx_byte;
            if (cnt_q == LEN_W'(LEN_BYTES - 1)) begin
              cnt_d   = '0;
              state_d = (len_d == '0) ? S_CHK : S_DATA;
            end else begin
              cnt_d = cnt_q + LEN_W'(1);
            end
          end
          S_DATA: begin
            mem_we_d    = 1'b1;
            mem_addr_d  = ADDR_W'(addr_q) + ADDR_W'(cnt_q);
            mem_wdata_d = rx_byte;
            chk_d       = chk_q ^ rx_byte;
            cnt_d       = cnt_q + LEN_W'(1);
            if (cnt_q == len_q - LEN_W'(1)) state_d = S_CHK;
          end
          S_CHK: begin
            if (rx_byte == chk_q) load_done_d = 1'b1;
            else                  load_err_d  = 1'b1;
            cpu_hold_d = 1'b0;
            state_d    = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
    busy_d = (state_d != S_IDLE);
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.busy      = busy_q;
  assign bus.load_done = load_done_q;
  assign bus.load_err  = load_err_q;

endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
Host-side writer for the processor data memory. It receives a framed byte stream over a UART line (8N1), decodes a start address and a length, and issues one-byte write strobes to a memory write port; the CPU and GPU read that memory. While a frame is in progress it asserts cpu_hold so the core pipeline freezes. At the end of the frame it reports success or a checksum or framing error.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200 baud); must be >= 4
ADDR_W, 32, width of the memory byte address
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  asynchronous, active-high reset
rx  input  1  UART serial input, idle high, asynchronous to clk
mem_we  output  1  one-cycle write strobe, one per data byte
mem_addr  output  ADDR_W  byte address for the write; valid while mem_we is high
mem_wdata  output  8  data byte; valid while mem_we is high
cpu_hold  output  1  high from acceptance of SYNC_BYTE until the frame ends
busy  output  1  high in every state except S_IDLE
load_done  output  1  one-cycle pulse when the checksum matches
load_err  output  1  sticky error flag; cleared when the next SYNC_BYTE is accepted

Behaviour:
- Reset (asynchronous): all outputs are 0, FSM is in S_IDLE, the rx synchroniser flops are 1.
- rx passes through a 2-flop synchroniser before any use.
- uart_rx sub-block:
  - A falling edge arms the start bit; the line is re-checked at CLKS_PER_BIT/2. If it is high again, the start is false and the sub-block returns to idle.
  - Data bits are sampled every CLKS_PER_BIT, LSB first.
  - The stop bit is sampled at mid-bit. Output byte_valid is a one-cycle pulse carrying byte[7:0], with frame_err = !stop.
  - byte_valid fires at the stop-bit sample point; receiving the next start bit needs no gap.
- Frame format: SYNC, ADDR (4 bytes, little-endian), LEN (2 bytes, little-endian, 0..65535), LEN data bytes, CHK.
- CHK = XOR of all ADDR, LEN and data bytes.
- FSM states: S_IDLE, S_ADDR, S_LEN, S_DATA, S_CHK.
- S_IDLE:
  - A byte equal to SYNC_BYTE with no frame_err moves to S_ADDR.
  - On that transition: cpu_hold=1, load_err=0, checksum accumulator=0, byte counter=0.
  - All other bytes are ignored.
- S_ADDR: after 4 bytes, moves to S_LEN. Address bits above ADDR_W are dropped.
- S_LEN: after 2 bytes, moves to S_DATA if LEN != 0, otherwise to S_CHK.
- S_DATA:
  - Each received byte produces mem_we=1 for exactly one cycle, registered, in the cycle after byte_valid, with mem_addr = base + index and mem_wdata = byte.
  - The address wraps modulo 2^ADDR_W.
  - After the LEN-th byte, moves to S_CHK.
- S_CHK:
  - Checksum match: load_done pulses 1 cycle, load_err stays 0.
  - Mismatch: load_err=1, no load_done.
  - In both cases cpu_hold drops in that same cycle and the FSM moves to S_IDLE.
- frame_err in any non-idle state: load_err=1, cpu_hold=0, return to S_IDLE. No further mem_we is issued for that frame.
- Writes already issued are never rolled back. An error means memory contents are undefined for that range.
- Latency: mem_we follows the stop-bit sample of its byte by exactly 1 clk. load_done and load_err follow the CHK stop sample by 1 clk.
- A SYNC_BYTE value appearing inside ADDR, LEN, data or CHK is treated as ordinary data; there is no resynchronisation mid-frame.
- Reset mid-frame drops the frame immediately; all outputs return to 0.

Decomposition:
- Shared package (mide_pkg): loader_state_t enum, SYNC_BYTE default, ADDR_LEN_BYTES=4, LEN_BYTES=2 constants.
- One sub-module, uart_rx (parameter CLKS_PER_BIT; ports clk, rst, rx_sync, byte_valid, byte, frame_err). The framing FSM, counters and checksum are at the top level.

Test Plan:
- Basic write (CLKS_PER_BIT=8): send A5, 00 01 00 00, 03 00, 11 22 33, CHK=0x01^0x03^0x11^0x22^0x33 -> exactly 3 mem_we pulses at addresses 0x100/0x101/0x102 with data 11/22/33, then load_done=1 for 1 cycle, cpu_hold low afterwards.
- Bad checksum: same frame with CHK=0x00 -> 3 writes, load_err=1 and stays high, no load_done, cpu_hold=0. The next valid frame clears load_err at its SYNC.
- LEN=0: A5, addr 0x10, 00 00, CHK=0x10 -> no mem_we, load_done pulse.
- Framing error: drive the stop bit low on the 2nd data byte of a LEN=4 frame -> 1 write only, load_err=1, FSM back in S_IDLE. A following good frame succeeds.
- Noise and address wrap: a 2-cycle low glitch on idle rx gives no byte. A frame with addr FFFFFFFF and LEN=2 writes to FFFFFFFF then 00000000.
- Async reset asserted during S_DATA -> all outputs 0 immediately, and a fresh frame then loads correctly.
